// File: rtl/fifo_uart_tx.sv
// Drains a sample FIFO and sends each sample over UART 8N1 as two bytes, high byte first.
// The read pulse, empty flag and read data are all treated as registered on the FIFO side.
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic [15:0]           samples_sent
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic             hi_byte;
  logic [7:0]       shift_reg;
  logic [7:0]       lo_byte;
  logic [15:0]      sample_ext;

  assign sample_ext = 16'(fifo_data);

  // Control path: sequencing, bit timing and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tx           <= 1'b1;
      fifo_rd_en   <= 1'b0;
      busy         <= 1'b0;
      samples_sent <= '0;
      bit_cnt      <= '0;
      bit_idx      <= '0;
      hi_byte      <= 1'b1;
    end else begin
      fifo_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo_empty) begin
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
            state      <= POP;
          end
        end
        POP: state <= LATCH;
        LATCH: begin
          tx      <= 1'b0;
          bit_cnt <= BIT_LAST;
          hi_byte <= 1'b1;
          state   <= START;
        end
        START: begin
          if (bit_cnt == '0) begin
            tx      <= shift_reg[0];
            bit_cnt <= BIT_LAST;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == '0) begin
            bit_cnt <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shift_reg[0];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt == '0) begin
            bit_cnt <= BIT_LAST;
            if (hi_byte) begin
              // Low byte follows back-to-back with no idle gap.
              hi_byte <= 1'b0;
              tx      <= 1'b0;
              state   <= START;
            end else begin
              hi_byte      <= 1'b1;
              busy         <= 1'b0;
              samples_sent <= samples_sent + 16'd1;
              bit_cnt      <= '0;
              state        <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data path: byte shifter is pre-shifted so shift_reg[0] is always the next bit to send.
  always_ff @(posedge clk) begin
    if (state == LATCH) begin
      shift_reg <= sample_ext[15:8];
      lo_byte   <= sample_ext[7:0];
    end else if (bit_cnt == '0 && (state == START || state == DATA)) begin
      shift_reg <= shift_reg >> 1;
    end else if (bit_cnt == '0 && state == STOP && hi_byte) begin
      shift_reg <= lo_byte;
    end
  end

endmodule
